// File: rtl/gb_dma_pkg.sv
// OAM DMA controller types.
//   dma_state_t : transfer sequencer states
//     IDLE  - no transfer
//     DELAY - start-up wait for the first M-cycle tick
//     READ  - source read request outstanding
//     WRITE - one-clk OAM write of the captured byte
//     WAIT  - pacing wait for the next M-cycle tick
package gb_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        WAIT  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/gb_mmu_addresses_pkg.sv
// Game Boy memory-map constants shared by bus-side blocks.
//   DMA_REG_ADDR_DEFAULT : OAM DMA trigger/readback register (FF46)
//   OAM_start / OAM_len  : object attribute memory window (FE00, 160 bytes)
//   dma_src_page()       : source page for a DMA trigger value, with the
//                          E000-FFFF echo area folded back onto C000-DFFF
package gb_mmu_addresses_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
    localparam logic [15:0] OAM_start            = 16'hFE00;
    localparam int unsigned OAM_len              = 160;

    // Pages E0..FF mirror work RAM at C0..DF, so the DMA reads the mirror.
    function automatic logic [7:0] dma_src_page(input logic [7:0] wr_val);
        logic [7:0] page;
        if (wr_val >= 8'hE0) begin
            page = wr_val - 8'h20;
        end else begin
            page = wr_val;
        end
        return page;
    endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: copies BYTES bytes from page (reg_wdata << 8) into OAM,
// one byte per M-cycle, when the CPU writes DMA_REG_ADDR.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   mcycle_tick           - one-clk strobe per M-cycle (paces the copy)
//   reg_wr_en/addr/wdata  - CPU register write port
//   reg_rdata             - last value written to DMA_REG_ADDR
//   dma_active            - transfer in progress
//   rd_req/addr/data/ack  - source read handshake (req held until ack)
//   oam_wr_en/addr/wdata  - one-clk OAM write strobe with index and data
// All outputs are registered.
module gb_oam_dma
    import gb_mmu_addresses_pkg::*;
    import gb_dma_pkg::*;
#(
    parameter int unsigned BYTES        = OAM_len,
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mcycle_tick,
    input  logic        reg_wr_en,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        dma_active,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        oam_wr_en,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);

    dma_state_t  state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  base_hi_q, base_hi_d;
    logic [7:0]  data_q, data_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_base_q, pend_base_d;

    logic [7:0]  reg_rdata_q, reg_rdata_d;
    logic        dma_active_q, dma_active_d;
    logic        rd_req_q, rd_req_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        oam_wr_en_q, oam_wr_en_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_wdata_q, oam_wdata_d;

    logic        trigger;
    logic [7:0]  new_base_hi;

    always_comb begin
        trigger     = reg_wr_en && (reg_addr == DMA_REG_ADDR);
        new_base_hi = dma_src_page(reg_wdata);

        state_d     = state_q;
        index_d     = index_q;
        base_hi_d   = base_hi_q;
        data_d      = data_q;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;
        reg_rdata_d = trigger ? reg_wdata : reg_rdata_q;

        unique case (state_q)
            IDLE: begin
            end
            DELAY: begin
                if (mcycle_tick) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_ack) begin
                    if (trigger || pend_q) begin
                        // The bus cycle is finished but its byte belongs to the
                        // abandoned transfer: drop it and restart on the newest base.
                        state_d   = DELAY;
                        index_d   = '0;
                        base_hi_d = trigger ? new_base_hi : pend_base_q;
                        pend_d    = 1'b0;
                    end else begin
                        data_d  = rd_data;
                        state_d = WRITE;
                    end
                end else if (trigger) begin
                    // Cannot withdraw a pending read; remember the retrigger
                    // and keep rd_req/rd_addr stable until the ack.
                    pend_d      = 1'b1;
                    pend_base_d = new_base_hi;
                end
            end
            WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mcycle_tick) begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Retrigger outside READ restarts immediately.
        if (trigger && (state_q != READ)) begin
            state_d   = DELAY;
            index_d   = '0;
            base_hi_d = new_base_hi;
            pend_d    = 1'b0;
        end

        // Outputs are registered copies of what the next state presents.
        dma_active_d = (state_d != IDLE);
        rd_req_d     = (state_d == READ);
        rd_addr_d    = rd_req_d ? ({base_hi_d, 8'h00} + {8'h00, index_d}) : '0;
        oam_wr_en_d  = (state_d == WRITE);
        oam_addr_d   = oam_wr_en_d ? index_d : '0;
        oam_wdata_d  = oam_wr_en_d ? data_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            index_q      <= '0;
            base_hi_q    <= '0;
            data_q       <= '0;
            pend_q       <= 1'b0;
            pend_base_q  <= '0;
            reg_rdata_q  <= '1;
            dma_active_q <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            oam_wr_en_q  <= 1'b0;
            oam_addr_q   <= '0;
            oam_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            base_hi_q    <= base_hi_d;
            data_q       <= data_d;
            pend_q       <= pend_d;
            pend_base_q  <= pend_base_d;
            reg_rdata_q  <= reg_rdata_d;
            dma_active_q <= dma_active_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            oam_wr_en_q  <= oam_wr_en_d;
            oam_addr_q   <= oam_addr_d;
            oam_wdata_q  <= oam_wdata_d;
        end
    end

    assign reg_rdata  = reg_rdata_q;
    assign dma_active = dma_active_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign oam_wr_en  = oam_wr_en_q;
    assign oam_addr   = oam_addr_q;
    assign oam_wdata  = oam_wdata_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma.
// A transaction-level model tracks which byte should be fetched/written next,
// the expected dma_active level and reg_rdata; a negedge monitor compares the
// DUT against it every cycle. Directed scenarios add literal expectations.
module tb_gb_oam_dma;

    localparam int unsigned BYTES = 160;

    logic        clk;
    logic        reset;
    logic        mcycle_tick;
    logic        reg_wr_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        dma_active;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_ack;
    logic        oam_wr_en;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;

    gb_oam_dma #(
        .BYTES        (160),
        .DMA_REG_ADDR (16'hFF46)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mcycle_tick (mcycle_tick),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .dma_active  (dma_active),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ack      (rd_ack),
        .oam_wr_en   (oam_wr_en),
        .oam_addr    (oam_addr),
        .oam_wdata   (oam_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Source memory contents as seen by the DMA.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [15:0] base_of(input logic [7:0] w);
        logic [7:0] h;
        h = (w >= 8'hE0) ? (w - 8'h20) : w;
        return {h, 8'h00};
    endfunction

    // ---------------- model state ----------------
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0;
    bit          m_got = 1'b0;
    bit          m_pending = 1'b0;
    logic [15:0] m_base = '0;
    logic [15:0] m_pend_base = '0;
    logic [7:0]  m_reg = 8'hFF;
    int unsigned m_idx = 0;
    int unsigned m_writes = 0;
    int unsigned prev_writes = 0;
    int unsigned wr_cnt [0:255];
    bit          first_seen = 1'b0;
    logic [15:0] first_rd_addr = '0;
    logic [15:0] last_ack_addr = '0;

    // ---------------- environment state ----------------
    int unsigned cyc_n = 0;
    int unsigned rd_wait = 0;
    bit          req_pending = 1'b0;
    bit          hold_en = 1'b0;
    logic [7:0]  hold_idx = '0;
    bit          slow_en = 1'b0;
    bit          force_ack = 1'b0;

    function automatic void model_restart(input logic [15:0] b);
        prev_writes = m_writes;
        m_writes    = 0;
        m_base      = b;
        m_idx       = 0;
        m_active    = 1'b1;
        m_got       = 1'b0;
        m_pending   = 1'b0;
        first_seen  = 1'b0;
        for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("dma_active", 32'(dma_active), 32'(m_active));
            chk("reg_rdata", 32'(reg_rdata), 32'(m_reg));
            chk("oam_wr_en", 32'(oam_wr_en), 32'(m_got));
            if (!m_active || m_got) begin
                chk("rd_req_quiet", 32'(rd_req), 32'd0);
            end else if (rd_req) begin
                chk("rd_addr", 32'(rd_addr), 32'(m_base + 16'(m_idx)));
                if (!first_seen) begin
                    first_seen    = 1'b1;
                    first_rd_addr = rd_addr;
                end
            end
            if (oam_wr_en && m_got) begin
                chk("oam_addr", 32'(oam_addr), 32'(m_idx[7:0]));
                chk("oam_wdata", 32'(oam_wdata), 32'(mem(m_base + 16'(m_idx))));
                wr_cnt[m_idx] = wr_cnt[m_idx] + 1;
                m_writes = m_writes + 1;
                m_idx    = m_idx + 1;
                m_got    = 1'b0;
                if (m_idx == BYTES) m_active = 1'b0;
            end

            // Inputs presented in this cycle take effect at the next edge.
            if (reset) begin
                m_active  = 1'b0;
                m_got     = 1'b0;
                m_pending = 1'b0;
                m_reg     = 8'hFF;
            end else begin
                if (rd_ack && (m_pending || (reg_wr_en && reg_addr == 16'hFF46))) begin
                    model_restart((reg_wr_en && reg_addr == 16'hFF46) ? base_of(reg_wdata) : m_pend_base);
                end else if (reg_wr_en && reg_addr == 16'hFF46 && req_pending) begin
                    m_pending   = 1'b1;
                    m_pend_base = base_of(reg_wdata);
                end else if (reg_wr_en && reg_addr == 16'hFF46) begin
                    model_restart(base_of(reg_wdata));
                end else if (rd_ack) begin
                    m_got         = 1'b1;
                    last_ack_addr = rd_addr;
                end
                if (reg_wr_en && reg_addr == 16'hFF46) m_reg = reg_wdata;
            end
        end
    end

    // One clock of stimulus: clear strobes, pace M-cycles, answer reads.
    task automatic step();
        int unsigned lat;
        @(posedge clk);
        #1;
        reg_wr_en   = 1'b0;
        rd_ack      = 1'b0;
        rd_data     = 8'($urandom);
        cyc_n       = cyc_n + 1;
        mcycle_tick = (cyc_n % 4 == 0);
        if (rd_req && !reset) begin
            req_pending = 1'b1;
            lat = (slow_en && rd_addr[7:0] == 8'd5) ? 10 : 1;
            if (force_ack || (!(hold_en && rd_addr[7:0] == hold_idx) && rd_wait >= lat)) begin
                rd_ack      = 1'b1;
                rd_data     = mem(rd_addr);
                rd_wait     = 0;
                req_pending = 1'b0;
            end else begin
                rd_wait = rd_wait + 1;
            end
        end else begin
            rd_wait     = 0;
            req_pending = 1'b0;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        step();
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while (dma_active && n < 4000) begin
            step();
            n++;
        end
        chk(name, 32'(!dma_active), 32'd1);
    endtask

    task automatic wait_rd(input logic [15:0] a);
        int unsigned n = 0;
        while (!(rd_req && rd_addr == a) && n < 2000) begin
            step();
            n++;
        end
        chk("wait_rd", 32'(rd_req && rd_addr == a), 32'd1);
    endtask

    task automatic wait_writes(input int unsigned k);
        int unsigned n = 0;
        while (m_writes < k && n < 4000) begin
            step();
            n++;
        end
        chk("wait_writes", m_writes, k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bad;
        reset = 1'b1; mcycle_tick = 1'b0; reg_wr_en = 1'b0;
        reg_addr = '0; reg_wdata = '0; rd_data = '0; rd_ack = 1'b0;
        for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
        repeat (3) step();

        // Reset state
        chk("rst_rdata", 32'(reg_rdata), 32'h00FF);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_oam_wr", 32'(oam_wr_en), 32'd0);
        chk("rst_oam_addr", 32'(oam_addr), 32'd0);
        chk("rst_oam_wdata", 32'(oam_wdata), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) step();

        // Plain transfer from C100
        do_write(16'hFF46, 8'hC1);
        chk("a_active", 32'(dma_active), 32'd1);
        chk("a_rdata", 32'(reg_rdata), 32'h00C1);
        wait_idle("a_done");
        chk("a_first", 32'(first_rd_addr), 32'h0000C100);
        chk("a_last", 32'(last_ack_addr), 32'h0000C19F);
        chk("a_count", m_writes, 32'd160);
        chk("a_idx0", wr_cnt[0], 32'd1);
        chk("a_idx159", wr_cnt[159], 32'd1);
        repeat (5) step();

        // Echo page E3 maps to C3
        do_write(16'hFF46, 8'hE3);
        wait_idle("e_done");
        chk("e_first", 32'(first_rd_addr), 32'h0000C300);
        chk("e_rdata", 32'(reg_rdata), 32'h00E3);
        chk("e_count", m_writes, 32'd160);
        repeat (5) step();

        // Slow ack on byte 5
        slow_en = 1'b1;
        do_write(16'hFF46, 8'hC1);
        wait_idle("s_done");
        slow_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 160; i++) if (wr_cnt[i] != 1) bad++;
        chk("s_each_once", bad, 32'd0);
        chk("s_idx5", wr_cnt[5], 32'd1);
        chk("s_count", m_writes, 32'd160);
        repeat (5) step();

        // Retrigger to D0 while read of idx 40 is outstanding
        hold_en = 1'b1; hold_idx = 8'd40;
        do_write(16'hFF46, 8'hC1);
        wait_rd(16'hC128);
        do_write(16'hFF46, 8'hD0);
        repeat (3) step();
        chk("r_held_addr", 32'(rd_addr), 32'h0000C128);
        hold_en = 1'b0;
        wait_idle("r_done");
        chk("r_prev", prev_writes, 32'd40);
        chk("r_first", 32'(first_rd_addr), 32'h0000D000);
        chk("r_count", m_writes, 32'd160);
        chk("r_idx40", wr_cnt[40], 32'd1);
        repeat (5) step();

        // Retrigger on the same clk as the ack of idx 10
        hold_en = 1'b1; hold_idx = 8'd10;
        do_write(16'hFF46, 8'hC1);
        wait_rd(16'hC10A);
        step();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        hold_en   = 1'b0;
        do_write(16'hFF46, 8'hC2);
        wait_idle("q_done");
        chk("q_prev", prev_writes, 32'd10);
        chk("q_first", 32'(first_rd_addr), 32'h0000C200);
        chk("q_count", m_writes, 32'd160);
        repeat (5) step();

        // Reset in the middle of a transfer
        do_write(16'hFF46, 8'hC1);
        wait_writes(80);
        reset = 1'b1;
        step();
        chk("x_active", 32'(dma_active), 32'd0);
        chk("x_rd_req", 32'(rd_req), 32'd0);
        chk("x_rd_addr", 32'(rd_addr), 32'd0);
        chk("x_oam_wr", 32'(oam_wr_en), 32'd0);
        chk("x_oam_addr", 32'(oam_addr), 32'd0);
        chk("x_oam_wdata", 32'(oam_wdata), 32'd0);
        chk("x_rdata", 32'(reg_rdata), 32'h00FF);
        reset = 1'b0;
        repeat (20) step();

        // Write to neighbouring register is ignored
        do_write(16'hFF47, 8'h12);
        repeat (10) step();
        chk("n_rdata", 32'(reg_rdata), 32'h00FF);
        chk("n_active", 32'(dma_active), 32'd0);
        chk("n_rd_req", 32'(rd_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gb_oam_dma.md
GB_OAM_DMA -- requirements
Module: gb_oam_dma

Interface
REQ-001 SHALL have parameter BYTES, default 160: bytes copied per transfer.
REQ-002 SHALL have parameter DMA_REG_ADDR, default 16'hFF46: trigger/readback register address.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mcycle_tick  input  1  one-clk strobe per M-cycle.
REQ-006 SHALL have port reg_wr_en  input  1  CPU register write strobe.
REQ-007 SHALL have port reg_addr  input  16  CPU register address.
REQ-008 SHALL have port reg_wdata  input  8  CPU write data.
REQ-009 SHALL have port reg_rdata  output  8  last value written to DMA_REG_ADDR.
REQ-010 SHALL have port dma_active  output  1  transfer in progress; CPU restricted to HRAM.
REQ-011 SHALL have port rd_req  output  1  source read request, held until rd_ack.
REQ-012 SHALL have port rd_addr  output  16  source byte address, stable while rd_req.
REQ-013 SHALL have port rd_data  input  8  source data, valid with rd_ack.
REQ-014 SHALL have port rd_ack  input  1  one-clk read completion.
REQ-015 SHALL have port oam_wr_en  output  1  one-clk OAM write strobe.
REQ-016 SHALL have port oam_addr  output  8  OAM byte index, 0..BYTES-1.
REQ-017 SHALL have port oam_wdata  output  8  OAM write data.

Function
REQ-018 SHALL trigger when reg_wr_en=1 and reg_addr=DMA_REG_ADDR; reg_rdata updates to reg_wdata next clk.
REQ-019 SHALL form source base: high byte = reg_wdata, or reg_wdata-8'h20 if reg_wdata>=8'hE0 (echo mapping); low byte 0.
REQ-020 SHALL implement states IDLE, DELAY, READ, WRITE, WAIT.
REQ-021 SHALL go from any state to DELAY on trigger, with index cleared to 0 and dma_active=1 from the next clk.
REQ-022 SHALL go from DELAY to READ on the first mcycle_tick after entry.
REQ-023 SHALL in READ drive rd_req=1 and rd_addr=base+index; on rd_ack, capture rd_data and enter WRITE.
REQ-024 SHALL in WRITE pulse oam_wr_en for exactly one clk, with oam_addr=index and oam_wdata=captured byte.
REQ-025 SHALL after WRITE go to IDLE if index=BYTES-1, else increment index and go to WAIT.
REQ-026 SHALL go from WAIT to READ on the next mcycle_tick; a slow rd_ack stretches the transfer without skipping bytes.
REQ-027 SHALL deassert dma_active the clk after the final OAM write.
REQ-028 SHALL, on a trigger while in READ awaiting rd_ack, keep rd_req until the ack arrives, discard that data without an OAM write, and then enter DELAY with the new base.
REQ-029 SHALL give a trigger on the same clk as rd_ack priority: data discarded, DELAY entered.
REQ-030 SHALL ignore register writes to other addresses.

Reset
REQ-031 SHALL on reset enter IDLE with index=0, base=0, reg_rdata=8'hFF, and all other outputs 0.
REQ-032 SHALL on reset mid-transfer abandon it immediately, with no further rd_req or oam_wr_en.

Structure
REQ-033 SHALL take DMA_REG_ADDR default, OAM_start and OAM_len from gb_mmu_addresses_pkg.
REQ-034 SHALL define the state enum in gb_dma_pkg.
REQ-035 SHALL be a single module with no sub-modules; the index counter is 8 bits.

Verification
REQ-036 SHALL cover: write 8'hC1, rd_ack 1 clk after rd_req -> 160 OAM writes, idx0 from C100, idx159 from C19F; dma_active low after the last write.
REQ-037 SHALL cover: write 8'hE3 -> first rd_addr=16'hC300.
REQ-038 SHALL cover: rd_ack delayed 10 clks on byte 5 -> byte 5 written once, bytes 6..159 follow, 160 writes total.
REQ-039 SHALL cover: retrigger 8'hD0 while awaiting ack at idx 40 -> no write for idx 40; next rd_addr=16'hD000; 160 writes after retrigger.
REQ-040 SHALL cover: reset asserted at idx 80 -> next clk all outputs 0 and reg_rdata=8'hFF.
REQ-041 SHALL cover: write to 16'hFF47 -> no activity and reg_rdata unchanged.
